// File: rtl/tcm_loader_pkg.sv
// Shared types and command codes for the boot-time TCM loader.
// The CHK state is only entered when TCM_LOADER_CHECKSUM_EN is defined.
package tcm_loader_pkg;

  typedef enum logic [2:0] {
    S_CMD,
    S_ADDR,
    S_LEN,
    S_DATA,
    S_WRITE,
    S_RUN,
    S_ERR,
    S_CHK
  } state_t;

  localparam logic [7:0] CMD_ITCM = 8'h01;
  localparam logic [7:0] CMD_DTCM = 8'h02;
  localparam logic [7:0] CMD_RUN  = 8'h03;

  function automatic logic accepts_byte(input state_t s);
    return s inside {S_CMD, S_ADDR, S_LEN, S_DATA, S_CHK};
  endfunction

  function automatic logic is_busy(input state_t s);
    return !(s inside {S_CMD, S_RUN, S_ERR});
  endfunction

endpackage

// File: rtl/tcm_loader_byte_assembler.sv
// Little-endian field assembler shared by the ADDR, LEN and DATA fields.
// next_word already includes the byte being shifted in, so it is valid alongside word_done.
module byte_assembler (
  input  logic        clk,
  input  logic        reset,
  input  logic        shift_en,
  input  logic [1:0]  last_idx,
  input  logic [7:0]  byte_in,
  output logic [31:0] next_word,
  output logic        word_done
);

  logic [1:0]  cnt;
  logic [31:0] shreg;

  assign next_word = {byte_in, shreg[31:8]};
  assign word_done = shift_en && (cnt == last_idx);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt   <= 2'd0;
      shreg <= 32'd0;
    end else if (shift_en) begin
      shreg <= next_word;
      cnt   <= word_done ? 2'd0 : cnt + 2'd1;
    end
  end

endmodule

// File: rtl/tcm_loader.sv
// Boot loader: byte stream -> ITCM/DTCM word writes, holds the cpu in reset until RUN.
// Optional trailing frame checksum byte is enabled by TCM_LOADER_CHECKSUM_EN.
module tcm_loader
  import tcm_loader_pkg::*;
#(
  parameter int ADDR_W = 14,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              itcm_we,
  output logic              dtcm_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_reset,
  output logic              busy,
  output logic              err
);

`ifdef TCM_LOADER_CHECKSUM_EN
  localparam state_t FRAME_END = S_CHK;
  logic [7:0] chk_sum;
`else
  localparam state_t FRAME_END = S_CMD;
`endif

  state_t            state, state_nxt;
  logic              is_dtcm;
  logic [ADDR_W-1:0] addr;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  len_val;
  logic              accept;
  logic              shift_en;
  logic [1:0]        last_idx;
  logic [31:0]       next_word;
  logic              word_done;

  assign accept   = in_valid && in_ready;
  assign shift_en = accept && (state inside {S_ADDR, S_LEN, S_DATA});
  assign last_idx = (state == S_LEN) ? 2'd1 : 2'd3;
  assign len_val  = CNT_W'(next_word[31:16]);

  byte_assembler u_asm (
    .clk       (clk),
    .reset     (reset),
    .shift_en  (shift_en),
    .last_idx  (last_idx),
    .byte_in   (in_data),
    .next_word (next_word),
    .word_done (word_done)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      S_CMD:
        if (accept) begin
          if (in_data == CMD_ITCM || in_data == CMD_DTCM) state_nxt = S_ADDR;
          else if (in_data == CMD_RUN)                    state_nxt = S_RUN;
          else                                            state_nxt = S_ERR;
        end
      S_ADDR:  if (word_done) state_nxt = S_LEN;
      S_LEN:   if (word_done) state_nxt = (len_val == '0) ? FRAME_END : S_DATA;
      S_DATA:  if (word_done) state_nxt = S_WRITE;
      S_WRITE: state_nxt = (count == CNT_W'(1)) ? FRAME_END : S_DATA;
`ifdef TCM_LOADER_CHECKSUM_EN
      S_CHK:   if (accept) state_nxt = (in_data == chk_sum) ? S_CMD : S_ERR;
`else
      S_CHK:   state_nxt = S_ERR;
`endif
      S_RUN:   state_nxt = S_RUN;
      S_ERR:   state_nxt = S_ERR;
      default: state_nxt = S_ERR;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state flop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_CMD;
      in_ready  <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
      cpu_reset <= 1'b1;
      itcm_we   <= 1'b0;
      dtcm_we   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= 32'd0;
      is_dtcm   <= 1'b0;
      addr      <= '0;
      count     <= '0;
`ifdef TCM_LOADER_CHECKSUM_EN
      chk_sum   <= 8'd0;
`endif
    end else begin
      state     <= state_nxt;
      in_ready  <= accepts_byte(state_nxt);
      busy      <= is_busy(state_nxt);
      err       <= (state_nxt == S_ERR);
      cpu_reset <= (state_nxt != S_RUN);
      itcm_we   <= 1'b0;
      dtcm_we   <= 1'b0;
      case (state)
        S_CMD:
          if (accept) begin
            is_dtcm <= (in_data == CMD_DTCM);
`ifdef TCM_LOADER_CHECKSUM_EN
            chk_sum <= 8'd0;
`endif
          end
        S_ADDR: if (word_done) addr <= {next_word[ADDR_W-1:2], 2'b00};
        S_LEN:  if (word_done) count <= len_val;
        S_DATA: begin
`ifdef TCM_LOADER_CHECKSUM_EN
          if (accept) chk_sum <= chk_sum + in_data;
`endif
          if (word_done) begin
            mem_addr  <= addr;
            mem_wdata <= next_word;
            itcm_we   <= !is_dtcm;
            dtcm_we   <= is_dtcm;
          end
        end
        S_WRITE: begin
          addr  <= addr + ADDR_W'(4);
          count <= count - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tcm_loader.sv
// Scoreboard bench for tcm_loader: stimulus queues expected TCM writes, a monitor pops on each strobe.
// Also runs the checksum frames when TCM_LOADER_CHECKSUM_EN is defined.
module tb_tcm_loader;

  localparam int ADDR_W = 14;

  typedef struct packed {
    logic              dtcm;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } exp_t;

  logic              clk;
  logic              reset;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              itcm_we;
  logic              dtcm_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              cpu_reset;
  logic              busy;
  logic              err;

  int          checks = 0;
  int          errors = 0;
  exp_t        sb[$];
  exp_t        mon_e;
  logic [31:0] frame_words[$];

  tcm_loader #(.ADDR_W(ADDR_W), .CNT_W(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .itcm_we   (itcm_we),
    .dtcm_we   (dtcm_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_reset (cpu_reset),
    .busy      (busy),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Present one byte and hold it until the loader takes it (bounded wait).
  task automatic applyStimulus(input logic [7:0] b, input bit gap);
    int n = 0;
    if (gap) @(negedge clk);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL handshake_timeout actual=in_ready_low expected=accept byte %h", b);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1 in_valid = 1'b0;
    end
  endtask

  task automatic sendFrame(input logic [7:0] cmd, input logic [31:0] a, input bit gap);
    logic [7:0]  sum;
    logic [15:0] cnt;
    sum = 8'd0;
    cnt = 16'(frame_words.size());
    applyStimulus(cmd, gap);
    for (int i = 0; i < 4; i++) applyStimulus(a[8*i +: 8], gap);
    applyStimulus(cnt[7:0], gap);
    applyStimulus(cnt[15:8], gap);
    foreach (frame_words[w]) begin
      for (int i = 0; i < 4; i++) begin
        applyStimulus(frame_words[w][8*i +: 8], gap);
        sum = sum + frame_words[w][8*i +: 8];
      end
    end
`ifdef TCM_LOADER_CHECKSUM_EN
    applyStimulus(sum, gap);
`endif
    frame_words.delete();
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (reset && (itcm_we || dtcm_we)) begin
      if (itcm_we && dtcm_we) checkOutput("both_strobes", 32'(dtcm_we), 32'(0));
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_write actual=addr %h data %h expected=no write", mem_addr, mem_wdata);
      end else begin
        mon_e = sb.pop_front();
        checkOutput("write_target", 32'(dtcm_we), 32'(mon_e.dtcm));
        checkOutput("write_addr", 32'(mem_addr), 32'(mon_e.addr));
        checkOutput("write_data", mem_wdata, mon_e.data);
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (2) @(negedge clk);
    checkOutput("rst_in_ready", 32'(in_ready), 32'(0));
    checkOutput("rst_itcm_we", 32'(itcm_we), 32'(0));
    checkOutput("rst_dtcm_we", 32'(dtcm_we), 32'(0));
    checkOutput("rst_mem_addr", 32'(mem_addr), 32'(0));
    checkOutput("rst_mem_wdata", mem_wdata, 32'(0));
    checkOutput("rst_cpu_reset", 32'(cpu_reset), 32'(1));
    checkOutput("rst_busy", 32'(busy), 32'(0));
    checkOutput("rst_err", 32'(err), 32'(0));
    reset = 1'b1;
    @(negedge clk);
    checkOutput("post_rst_in_ready", 32'(in_ready), 32'(1));

    $display("[TB] ITCM load of two words at 0x100");
    sb.push_back('{1'b0, 14'h0100, 32'h00000013});
    sb.push_back('{1'b0, 14'h0104, 32'h00100093});
    frame_words.push_back(32'h00000013);
    frame_words.push_back(32'h00100093);
    sendFrame(8'h01, 32'h00000100, 1'b0);
    repeat (2) @(negedge clk);
    checkOutput("load_busy_idle", 32'(busy), 32'(0));
    checkOutput("load_cpu_reset", 32'(cpu_reset), 32'(1));

    $display("[TB] Empty DTCM frame, then one DTCM word with input gaps");
    sendFrame(8'h02, 32'h00000000, 1'b0);
    repeat (2) @(negedge clk);
    checkOutput("empty_busy", 32'(busy), 32'(0));
    sb.push_back('{1'b1, 14'h0020, 32'h12345678});
    frame_words.push_back(32'h12345678);
    sendFrame(8'h02, 32'h00000020, 1'b1);

    $display("[TB] Address wrap with unaligned high address");
    sb.push_back('{1'b0, 14'h3FFC, 32'h44332211});
    sb.push_back('{1'b0, 14'h0000, 32'h88776655});
    frame_words.push_back(32'h44332211);
    frame_words.push_back(32'h88776655);
    sendFrame(8'h01, 32'hFFFFFFFF, 1'b0);

    $display("[TB] Reset in the middle of a data word");
    applyStimulus(8'h01, 1'b0);
    applyStimulus(8'h00, 1'b0);
    applyStimulus(8'h02, 1'b0);
    applyStimulus(8'h00, 1'b0);
    applyStimulus(8'h00, 1'b0);
    applyStimulus(8'h01, 1'b0);
    applyStimulus(8'h00, 1'b0);
    applyStimulus(8'hAA, 1'b0);
    applyStimulus(8'hBB, 1'b0);
    checkOutput("mid_frame_busy", 32'(busy), 32'(1));
    #2 reset = 1'b0;
    @(negedge clk);
    checkOutput("abort_busy", 32'(busy), 32'(0));
    checkOutput("abort_in_ready", 32'(in_ready), 32'(0));
    checkOutput("abort_cpu_reset", 32'(cpu_reset), 32'(1));
    reset = 1'b1;
    sb.push_back('{1'b0, 14'h0040, 32'hDEADBEEF});
    frame_words.push_back(32'hDEADBEEF);
    sendFrame(8'h01, 32'h00000040, 1'b0);

`ifdef TCM_LOADER_CHECKSUM_EN
    $display("[TB] Checksum frame with matching and mismatching CHK byte");
    sb.push_back('{1'b0, 14'h0300, 32'h04030201});
    applyStimulus(8'h01, 1'b0);
    applyStimulus(8'h00, 1'b0);
    applyStimulus(8'h03, 1'b0);
    applyStimulus(8'h00, 1'b0);
    applyStimulus(8'h00, 1'b0);
    applyStimulus(8'h01, 1'b0);
    applyStimulus(8'h00, 1'b0);
    for (int i = 1; i <= 4; i++) applyStimulus(8'(i), 1'b0);
    applyStimulus(8'h0A, 1'b0);
    @(negedge clk);
    checkOutput("chk_good_err", 32'(err), 32'(0));
    checkOutput("chk_good_busy", 32'(busy), 32'(0));
    sb.push_back('{1'b1, 14'h0310, 32'h04030201});
    applyStimulus(8'h02, 1'b0);
    applyStimulus(8'h10, 1'b0);
    applyStimulus(8'h03, 1'b0);
    applyStimulus(8'h00, 1'b0);
    applyStimulus(8'h00, 1'b0);
    applyStimulus(8'h01, 1'b0);
    applyStimulus(8'h00, 1'b0);
    for (int i = 1; i <= 4; i++) applyStimulus(8'(i), 1'b0);
    applyStimulus(8'h0B, 1'b0);
    @(negedge clk);
    checkOutput("chk_bad_err", 32'(err), 32'(1));
    checkOutput("chk_bad_in_ready", 32'(in_ready), 32'(0));
    doReset();
`endif

    $display("[TB] Bad command byte");
    applyStimulus(8'h07, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("badcmd_err", 32'(err), 32'(1));
      checkOutput("badcmd_in_ready", 32'(in_ready), 32'(0));
      checkOutput("badcmd_cpu_reset", 32'(cpu_reset), 32'(1));
    end
    doReset();
    @(negedge clk);
    checkOutput("after_err_reset_err", 32'(err), 32'(0));

    $display("[TB] Load then RUN");
    sb.push_back('{1'b0, 14'h0000, 32'hCAFEF00D});
    frame_words.push_back(32'hCAFEF00D);
    sendFrame(8'h01, 32'h00000000, 1'b0);
    @(negedge clk);
    checkOutput("pre_run_cpu_reset", 32'(cpu_reset), 32'(1));
    applyStimulus(8'h03, 1'b0);
    @(negedge clk);
    checkOutput("run_cpu_reset", 32'(cpu_reset), 32'(0));
    checkOutput("run_err", 32'(err), 32'(0));
    checkOutput("run_busy", 32'(busy), 32'(0));
    in_valid = 1'b1;
    in_data  = 8'h01;
    for (int i = 0; i < 4; i++) begin
      checkOutput("run_in_ready", 32'(in_ready), 32'(0));
      @(negedge clk);
    end
    in_valid = 1'b0;
    checkOutput("run_cpu_reset_hold", 32'(cpu_reset), 32'(0));

    repeat (3) @(negedge clk);
    checkOutput("scoreboard_empty", 32'(sb.size()), 32'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tcm_loader.md
Name: tcm_loader

Overview:
- Boot-time loader directly upstream of the cpu top.
- Takes a byte stream (host/UART side) over a valid/ready handshake and assembles little-endian 32-bit words.
- Writes the words into the instruction or data TCM and holds the cpu in reset until a RUN command arrives.
- Its cpu_reset output drives the cpu's active-high reset input.

Parameters:
- ADDR_W, 14, TCM byte-address width; address wraps modulo 2**ADDR_W.
- CNT_W, 16, width of the word-count field and counter.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  input byte valid
- in_data  in  8  input byte
- in_ready  out  1  loader accepts byte this cycle
- itcm_we  out  1  one-cycle ITCM write strobe
- dtcm_we  out  1  one-cycle DTCM write strobe
- mem_addr  out  ADDR_W  word-aligned byte address for write (bits[1:0]=0)
- mem_wdata  out  32  write data
- cpu_reset  out  1  active-high reset to cpu; released only by RUN
- busy  out  1  frame in progress (state not CMD/RUN/ERR)
- err  out  1  sticky protocol error

Behaviour:
- Byte accepted when in_valid && in_ready. At most one byte per cycle.
- Frame format:
  - CMD byte: 0x01 = ITCM, 0x02 = DTCM, 0x03 = RUN.
  - For 0x01/0x02 only: 4 address bytes LE (low ADDR_W bits used, bits[1:0] forced 0), then 2 count bytes LE, then count×4 data bytes LE.
- FSM states: CMD, ADDR, LEN, DATA, WRITE, RUN, ERR.
  - CMD: in_ready=1.
    - 0x01/0x02 -> ADDR, latch target.
    - 0x03 -> RUN.
    - Any other value -> ERR.
  - ADDR: 4 bytes -> LEN. Byte counter 2 bits.
  - LEN: 2 bytes. If count==0 -> CMD, else -> DATA.
  - DATA: shift bytes into word register. On the 4th byte -> WRITE.
  - WRITE: in_ready=0 for exactly 1 cycle.
    - Pulse itcm_we or dtcm_we for this cycle, with mem_addr/mem_wdata stable.
    - Then: addr += 4 (wrap mod 2**ADDR_W), count -= 1.
    - count reaches 0 -> CMD, else -> DATA.
  - RUN: cpu_reset=0, in_ready=0. Terminal until reset.
  - ERR: err=1, in_ready=0, cpu_reset stays 1. Terminal until reset.
- Latency: write strobe asserts the cycle after the 4th data byte is accepted. Throughput is 5 cycles per word at full input rate.
- in_valid gaps at any point: state and partial word held, no timeout.
- mem_addr/mem_wdata hold their last values outside WRITE. Only one of itcm_we/dtcm_we is ever high.
- Reset values: in_ready=0 while reset low, 1 from first cycle after release (CMD). itcm_we=0, dtcm_we=0, mem_addr=0, mem_wdata=0, cpu_reset=1, busy=0, err=0.
- Reset mid-frame: all state cleared asynchronously, partial word discarded, cpu_reset=1.
- count=0xFFFF is legal; the address wraps silently.

Optional Feature:
- Macro TCM_LOADER_CHECKSUM_EN.
- Defined:
  - After the last data word, a CHK state accepts one byte, equal to the 8-bit mod-256 sum of all data bytes in the frame.
  - Match -> CMD. Mismatch -> ERR.
  - Writes already performed are not undone.
  - count==0 still requires a CHK byte of 0x00.
- Undefined: no CHK state; the frame ends after the last WRITE.

Decomposition:
- Package tcm_loader_pkg:
  - state enum typedef.
  - Command constants CMD_ITCM=8'h01, CMD_DTCM=8'h02, CMD_RUN=8'h03.
- Sub-module byte_assembler:
  - 2-bit byte counter plus 32-bit LE shift register with word_done pulse.
  - Reused by the ADDR, LEN and DATA fields.

Test Plan:
- ITCM load: 01, 00 01 00 00, 02 00, 13 00 00 00, 93 00 10 00 -> itcm_we pulses:
  - addr 0x100, wdata 0x00000013.
  - addr 0x104, wdata 0x00100093.
  - dtcm_we never high.
- RUN after load: 03 -> cpu_reset falls the next cycle, in_ready=0. Further bytes are not accepted.
- Bad command: 07 -> err=1, cpu_reset stays 1, in_ready=0 until reset.
- Zero count + backpressure: 02, 00×4, 00 00, then DTCM 1 word with in_valid toggling every other cycle -> no strobe for the empty frame; a single correct dtcm_we for the second frame.
- Reset mid-DATA after 2 data bytes, then full ITCM frame -> no write from the aborted frame; new frame writes correctly.
- With TCM_LOADER_CHECKSUM_EN, word 01 02 03 04:
  - CHK 0x0A -> back to CMD, err=0.
  - CHK 0x0B -> err=1.
